// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns: one shared column-mix unit walks the state
// one 32-bit column per cycle; a bypass path skips mixing for the final round.

module mix_column (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    always_comb begin
        a0 = col_in[31:24];
        a1 = col_in[23:16];
        a2 = col_in[15:8];
        a3 = col_in[7:0];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        // 3*a is folded in as xtime(a)^a
        col_out[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
        col_out[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
        col_out[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
        col_out[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
    end
endmodule

module mix_columns_seq #(
    parameter  int NCOLS = 4,
    localparam int W     = 32 * NCOLS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bypass,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);
    localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(NCOLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  state_reg_q, state_reg_d;
    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [W-1:0]  out_data_q, out_data_d;

    logic          accept;
    logic [31:0]   col_sel;
    logic [31:0]   col_mixed;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign out_data  = out_data_q;

    always_comb begin
        col_sel = '0;
        for (int i = 0; i < NCOLS; i++) begin
            if (col_cnt_q == CW'(i)) col_sel = state_reg_q[W-1-32*i -: 32];
        end
    end

    mix_column u_mix (
        .col_in  (col_sel),
        .col_out (col_mixed)
    );

    always_comb begin
        state_d     = state_q;
        state_reg_d = state_reg_q;
        col_cnt_d   = col_cnt_q;
        out_data_d  = out_data_q;

        case (state_q)
            BUSY: begin
                for (int i = 0; i < NCOLS; i++) begin
                    if (col_cnt_q == CW'(i)) out_data_d[W-1-32*i -: 32] = col_mixed;
                end
                if (col_cnt_q == LAST_COL) begin
                    col_cnt_d = '0;
                    state_d   = DONE;
                end else begin
                    col_cnt_d = col_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: ;
        endcase

        // accept only happens in IDLE or a draining DONE, so it overrides the above
        if (accept) begin
            state_reg_d = in_data;
            col_cnt_d   = '0;
            if (in_bypass) begin
                out_data_d = in_data;
                state_d    = DONE;
            end else begin
                state_d = BUSY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            state_reg_q <= '0;
            col_cnt_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            state_reg_q <= state_reg_d;
            col_cnt_q   <= col_cnt_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed + randomized bench for mix_columns_seq (NCOLS=4 and NCOLS=8 instances)
// checked against a matrix-form GF(2^8) reference model.

module tb_mix_columns_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         v4, r4, b4, ov4, or4, busy4;
    logic [127:0] d4, od4;
    logic         v8, r8, b8, ov8, or8, busy8;
    logic [255:0] d8, od8;

    int n_cmp = 0;
    int n_err = 0;

    mix_columns_seq #(.NCOLS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(r4), .in_bypass(b4), .in_data(d4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .busy(busy4)
    );

    mix_columns_seq #(.NCOLS(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(r8), .in_bypass(b8), .in_data(d8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int b = 0; b < 8; b++) begin
            if (k[b]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // State occupies the low 32*ncols bits; column 0 is the most significant word.
    function automatic logic [255:0] ref_mix(input logic [255:0] s, input int ncols);
        int m [4][4];
        logic [255:0] r;
        logic [31:0]  col;
        logic [7:0]   acc;
        m = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
        r = '0;
        for (int c = 0; c < ncols; c++) begin
            col = s[32*ncols-1-32*c -: 32];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(col[31-8*k -: 8], m[row][k]);
                r[32*ncols-1-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] ref4(input logic [127:0] s);
        logic [255:0] t;
        t = ref_mix({128'b0, s}, 4);
        return t[127:0];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // lat = number of clock edges after the accept edge until out_valid is seen
    task automatic wait_valid4(output int lat, output logic saw_busy);
        lat = 0;
        saw_busy = 1'b0;
        while (1) begin
            if (busy4) saw_busy = 1'b1;
            if (ov4 || lat >= 40) break;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op4(input logic [127:0] d, input logic byp, output int lat,
                       output logic [127:0] res, output logic saw_busy);
        v4 = 1'b1; d4 = d; b4 = byp;
        chk("in_ready_before_accept", r4, 1);
        @(posedge clk); #1;
        v4 = 1'b0;
        d4 = rnd128();
        wait_valid4(lat, saw_busy);
        res = od4;
    endtask

    initial begin
        int           lat;
        logic         sb;
        logic [127:0] res, held, x, snap;
        logic [127:0] bq [20];
        logic [127:0] eq [20];
        int           ai, oi, cyc, last_out;
        logic         acc, hs;
        logic [255:0] s8;

        rst_n = 1'b0;
        v4 = 0; b4 = 0; d4 = '0; or4 = 1;
        v8 = 0; b8 = 0; d8 = '0; or8 = 1;
        #2;
        chk("rst_out_valid", ov4, 0);
        chk("rst_out_data", od4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_in_ready", r4, 1);
        chk("rst8_out_data", od8, 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", r4, 1);
        chk("idle_out_valid", ov4, 0);

        // Known-answer mix; the result appears after NCOLS mix edges
        x = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c};
        op4(x, 1'b0, lat, res, sb);
        chk("kat_latency", lat, 4);
        chk("kat_data", res, {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8});
        chk("kat_model", res, ref4(x));
        chk("kat_saw_busy", sb, 1);
        @(posedge clk); #1;
        chk("kat_back_to_idle", ov4, 0);

        // Bypass: valid right after the accept edge, data unchanged, never busy
        x = 128'h00112233_44556677_8899aabb_ccddeeff;
        op4(x, 1'b1, lat, res, sb);
        chk("byp_latency", lat, 0);
        chk("byp_data", res, x);
        chk("byp_busy", sb, 0);
        @(posedge clk); #1;

        // Backpressure with junk on the input while in_ready is low
        or4 = 1'b0;
        x = rnd128();
        op4(x, 1'b0, lat, res, sb);
        chk("bp_latency", lat, 4);
        chk("bp_data", res, ref4(x));
        held = res;
        v4 = 1'b1; b4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d4 = rnd128();
            @(posedge clk); #1;
            chk("bp_out_valid", ov4, 1);
            chk("bp_out_data_stable", od4, held);
            chk("bp_in_ready", r4, 0);
        end
        d4 = {4{32'hd4d4d4d5}}; b4 = 1'b0; or4 = 1'b1;
        #1;
        chk("bp_release_in_ready", r4, 1);
        @(posedge clk); #1;
        v4 = 1'b0;
        chk("bp_reload_busy", busy4, 1);
        wait_valid4(lat, sb);
        chk("bp_reload_latency", lat, 4);
        chk("bp_reload_data", od4, {4{32'hd5d5d7d6}});

        // Bypass reload while draining DONE: out_valid stays high, data updates
        x = rnd128();
        v4 = 1'b1; b4 = 1'b1; d4 = x;
        @(posedge clk); #1;
        v4 = 1'b0; b4 = 1'b0;
        chk("byp_reload_valid", ov4, 1);
        chk("byp_reload_data", od4, x);
        @(posedge clk); #1;
        chk("byp_reload_idle", ov4, 0);

        // Back-to-back stream of 20 random states
        for (int i = 0; i < 20; i++) begin
            bq[i] = rnd128();
            eq[i] = ref4(bq[i]);
        end
        ai = 0; oi = 0; cyc = 0; last_out = 0;
        v4 = 1'b1; b4 = 1'b0; d4 = bq[0]; or4 = 1'b1;
        while (oi < 20 && cyc < 300) begin
            acc  = v4 && r4;
            hs   = ov4 && or4;
            snap = od4;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                ai++;
                if (ai < 20) d4 = bq[ai];
                else v4 = 1'b0;
            end
            if (hs) begin
                chk("stream_data", snap, eq[oi]);
                if (oi > 0) chk("stream_interval", cyc - last_out, 5);
                last_out = cyc;
                oi++;
            end
        end
        chk("stream_count", oi, 20);
        v4 = 1'b0;
        @(posedge clk); #1;

        // Reset two cycles into BUSY discards the partial result immediately
        v4 = 1'b1; d4 = rnd128(); b4 = 1'b0;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", busy4, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ov4, 0);
        chk("midrst_out_data", od4, 0);
        chk("midrst_in_ready", r4, 1);
        chk("midrst_busy", busy4, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        x = rnd128();
        op4(x, 1'b0, lat, res, sb);
        chk("postrst_latency", lat, 4);
        chk("postrst_data", res, ref4(x));
        @(posedge clk); #1;

        // 256-bit state on the NCOLS=8 instance
        s8 = {8{32'hdb135345}};
        chk("n8_in_ready", r8, 1);
        v8 = 1'b1; d8 = s8;
        @(posedge clk); #1;
        v8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("n8_latency", lat, 8);
        chk("n8_data", od8, {8{32'h8e4da1bc}});
        chk("n8_model", od8, ref_mix(s8, 8));
        s8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        v8 = 1'b1; d8 = s8;
        @(posedge clk); #1;
        v8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("n8_rand_latency", lat, 8);
        chk("n8_rand_data", od8, ref_mix(s8, 8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
